// File: rtl/seed_pkg.sv
// Shared constants and FSM state encoding for the SEED output serializer.
package seed_pkg;

    localparam int BYTE_W         = 8;
    localparam int SEED_BLOCK_W   = 128;
    localparam int SEED_NUM_BYTES = SEED_BLOCK_W / BYTE_W;

    typedef logic [2:0] seed_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ACK_HI = 3'd2;
    localparam logic [2:0] ST_ACK_LO = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

endpackage

// File: rtl/seed_hs_gap_timer.sv
// Loadable down-counter that spaces byte strobes apart. Freezes while
// dec_en is low; expired flags the last counted cycle so the FSM can launch
// the next strobe on that edge.
module seed_hs_gap_timer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec_en,
    output logic expired
);

    localparam int CNT_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] count;

    // Reload on entry to the gap, count down while enabled, stop at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/seed_byte_serializer.sv
// Output stage of the SEED core: captures a finished block and streams it
// MSB byte first to the host over a 4-phase load_rpi3/rpi_ack handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no block held, waiting for seed_valid
// LOAD      | byte ready; waiting for in_en=1 and a released (low) ack
// ACK_HI    | load_rpi3 high, waiting for the host to raise rpi_ack
// ACK_LO    | byte taken, waiting for the host to drop rpi_ack
// GAP       | spacing between bytes, timer frozen while in_en=0
// FIN       | one-cycle done pulse; may capture the next block
module seed_byte_serializer
    import seed_pkg::*;
#(
    parameter int NUM_BYTES  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_en,
    input  logic                        seed_valid,
    input  logic [BYTE_W*NUM_BYTES-1:0] seed_data,
    input  logic                        rpi_ack,
    output logic [BYTE_W-1:0]           part_SEED,
    output logic                        load_rpi3,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int BLK_W = BYTE_W * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES) + 1;

    seed_state_t      state;
    logic [BLK_W-1:0] shreg;
    logic [CNT_W-1:0] byte_cnt;

    logic last_byte;
    logic can_launch;
    logic gap_load;
    logic gap_dec;
    logic gap_expired;
    logic in_transfer;

    assign last_byte   = (byte_cnt == CNT_W'(NUM_BYTES));
    // A still-high ack is stale; a byte is only offered once the host has let go.
    assign can_launch  = in_en && !rpi_ack;
    assign gap_load    = (state == ST_ACK_LO) && !rpi_ack && !last_byte && (GAP_CYCLES != 0);
    assign gap_dec     = (state == ST_GAP) && in_en;
    assign in_transfer = (state != ST_IDLE) && (state != ST_FIN);

    seed_hs_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (gap_load),
        .dec_en (gap_dec),
        .expired(gap_expired)
    );

    // Handshake FSM with registered outputs; a reset drops everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            byte_cnt  <= '0;
            part_SEED <= '0;
            load_rpi3 <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (seed_valid && in_transfer) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (seed_valid) begin
                        shreg    <= seed_data;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (can_launch) begin
                        load_rpi3 <= 1'b1;
                        part_SEED <= shreg[BLK_W-1 -: BYTE_W];
                        state     <= ST_ACK_HI;
                    end
                end
                ST_ACK_HI: begin
                    if (rpi_ack) begin
                        load_rpi3 <= 1'b0;
                        shreg     <= shreg << BYTE_W;
                        byte_cnt  <= byte_cnt + 1'b1;
                        state     <= ST_ACK_LO;
                    end else if (!in_en) begin
                        // Withdraw the unacknowledged byte; it is re-offered from LOAD.
                        load_rpi3 <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_ACK_LO: begin
                    if (!rpi_ack) begin
                        if (last_byte) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FIN;
                        end else if (GAP_CYCLES == 0) begin
                            if (in_en) begin
                                load_rpi3 <= 1'b1;
                                part_SEED <= shreg[BLK_W-1 -: BYTE_W];
                                state     <= ST_ACK_HI;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (in_en && gap_expired) begin
                        if (can_launch) begin
                            load_rpi3 <= 1'b1;
                            part_SEED <= shreg[BLK_W-1 -: BYTE_W];
                            state     <= ST_ACK_HI;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_FIN: begin
                    if (seed_valid) begin
                        shreg    <= seed_data;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seed_byte_serializer.md
Name: seed_byte_serializer

Overview:
Downstream output stage of the SEED core. It captures the 128-bit encrypted/decrypted block when the core signals completion. It streams that block MSB-byte-first to the Raspberry Pi 3 over the 8-bit part_SEED bus. Each byte uses a 4-phase load_rpi3/rpi_ack handshake, and the block pulses done after the last byte is acknowledged.

Parameters:
NUM_BYTES, 16, bytes per block (block width = 8*NUM_BYTES)
GAP_CYCLES, 2, idle cycles between ack release and next load_rpi3 assertion (>=0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_en  in  1  global enable; when low, FSM holds state (no new strobe issued)
seed_valid  in  1  one-cycle pulse: seed_data holds a finished block
seed_data  in  8*NUM_BYTES  result block, byte 0 = bits [8*NUM_BYTES-1 -: 8]
rpi_ack  in  1  host acknowledge (level, 4-phase)
part_SEED  out  8  current output byte
load_rpi3  out  1  byte-valid strobe to host
busy  out  1  high from capture until done
done  out  1  one-cycle pulse after last byte handshake completes
overrun  out  1  sticky: seed_valid arrived while busy; cleared only by reset

Behaviour:
- Reset (reset=0, async): state IDLE; part_SEED=8'h00, load_rpi3=0, busy=0, done=0, overrun=0; shift register and byte counter zeroed. Reset mid-transfer aborts immediately; the partial block is discarded.
- IDLE: on seed_valid=1, latch seed_data into the shift register, counter=0, busy=1, go to LOAD on the next edge.
  - Capture happens regardless of in_en.
- LOAD: part_SEED = shift register top byte; load_rpi3=1 when in_en=1.
  - Transition to ACK_HI is registered, so load_rpi3 first goes high the cycle after capture.
  - Latency: seed_valid at edge N gives load_rpi3=1 after edge N+1.
  - load_rpi3 is held high, with part_SEED stable, until rpi_ack=1 is sampled.
- ACK_HI: on sampled rpi_ack=1, drop load_rpi3, shift register left by 8, counter+1, go to ACK_LO.
  - part_SEED keeps the acknowledged byte until the next LOAD.
- ACK_LO: wait for rpi_ack=0.
  - If counter==NUM_BYTES, go to FIN.
  - Else go to GAP; go directly to LOAD if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
  - A seed_valid in the FIN cycle is accepted as a new block, with no overrun.
- in_en=0: LOAD does not assert load_rpi3 (or deasserts it if not yet acked); the GAP counter freezes.
  - ACK_HI and ACK_LO still track rpi_ack, so the host handshake is never broken.
- seed_valid while busy (any state but IDLE/FIN): ignored, data not overwritten, overrun set.
- rpi_ack=1 already high when entering LOAD: treated as a stale ack. The FSM waits for rpi_ack=0 first, so each byte needs a fresh rising ack.
- Counter width: clog2(NUM_BYTES)+1. No wrap; FIN is reached exactly at NUM_BYTES.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package seed_pkg: state enum (IDLE, LOAD, ACK_HI, ACK_LO, GAP, FIN), BYTE_W=8, SEED_BLOCK_W=128.
- One sub-module: seed_hs_gap_timer (loadable down-counter with freeze for GAP_CYCLES); everything else lives in the top FSM.

Test Plan:
1. Nominal: seed_data=128'h00112233445566778899AABBCCDDEEFF, host acks each strobe 1 cycle after it and releases 1 cycle later -> part_SEED sequence 00,11,...,FF on 16 load_rpi3 strobes. done pulses once, 1 cycle after the 16th ack low. busy high throughout; overrun=0.
2. Slow host: ack delayed 7 cycles per byte -> load_rpi3 and part_SEED stable for the full wait. Exactly 16 strobes; byte values as in test 1.
3. Overrun: second seed_valid (data all 8'hAA) during byte 5 -> overrun=1 sticky. Output remains the original block and no AA byte appears. The next block after done is accepted normally.
4. Enable gating: in_en=0 for 10 cycles in GAP after byte 3 -> no strobe while low. Resumes with byte 4 (0x44) once in_en returns to 1; total gap = GAP_CYCLES + pause.
5. Reset mid-transfer: reset=0 asynchronously during byte 8's ACK_HI -> outputs return to reset values the same cycle and no done pulse. A new block after reset streams from its byte 0.
6. Stale ack / GAP_CYCLES=0 build: rpi_ack held high at capture -> no advance until ack falls and rises again. With GAP=0, back-to-back bytes show load_rpi3 re-asserting the cycle after ack low is sampled.
